// File: rtl/operand_stage_pkg.sv
// operand_stage shared definitions: opcodes, funct codes,
// operand-select encodings and the per-instruction decode.
package operand_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [2:0] {
        OPSEL_ZERO,
        OPSEL_REG,
        OPSEL_LINK,
        OPSEL_SIMM,
        OPSEL_ZIMM,
        OPSEL_HIMM
    } opsel_e;

    typedef struct packed {
        opsel_e sel_1;
        opsel_e sel_2;
        logic   rs_used;
        logic   rt_used;
        logic   store;
    } dec_t;

    // rs/rt count as used only when they feed an operand or store data,
    // so an unused field never raises a load-use stall.
    function automatic dec_t decode(
        input logic [5:0] op,
        input logic [5:0] funct
    );
        dec_t d;
        d.sel_1   = OPSEL_ZERO;
        d.sel_2   = OPSEL_ZERO;
        d.rs_used = 1'b0;
        d.rt_used = 1'b0;
        d.store   = 1'b0;
        unique case (op)
            OP_SPECIAL: begin
                if (funct == FN_JALR) begin
                    d.sel_1 = OPSEL_LINK;
                end else begin
                    d.sel_1 = OPSEL_REG;
                end
                d.sel_2 = OPSEL_REG;
            end
            OP_JAL: begin
                d.sel_1 = OPSEL_LINK;
            end
            OP_ADDIU: begin
                d.sel_1 = OPSEL_REG;
                d.sel_2 = OPSEL_SIMM;
            end
            OP_LUI: begin
                d.sel_1 = OPSEL_REG;
                d.sel_2 = OPSEL_HIMM;
            end
            OP_ANDI, OP_ORI: begin
                d.sel_1 = OPSEL_REG;
                d.sel_2 = OPSEL_ZIMM;
            end
            OP_LB, OP_LBU, OP_LH, OP_LW: begin
                d.sel_1 = OPSEL_REG;
                d.sel_2 = OPSEL_SIMM;
            end
            OP_SB, OP_SH, OP_SW: begin
                d.sel_1 = OPSEL_REG;
                d.sel_2 = OPSEL_SIMM;
                d.store = 1'b1;
            end
            default: begin
            end
        endcase
        d.rs_used = (d.sel_1 == OPSEL_REG);
        d.rt_used = (d.sel_2 == OPSEL_REG) || d.store;
        return d;
    endfunction

endpackage

// File: rtl/operand_stage_fwd_sel.sv
// Source resolver: picks the youngest matching forwarding port,
// falling back to register file data; register 0 never forwards.
module operand_fwd_sel #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int FWD_PORTS = 2
) (
    input  logic [REG_AW-1:0]           src,
    input  logic [DATA_W-1:0]           reg_data,
    input  logic [FWD_PORTS-1:0]        fwd_en,
    input  logic [FWD_PORTS-1:0]        fwd_pending,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr,
    input  logic [FWD_PORTS*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]           value,
    output logic                        pending
);

    // Walk oldest to youngest so the lowest matching index lands last.
    always_comb begin
        value   = reg_data;
        pending = 1'b0;
        for (int i = FWD_PORTS - 1; i >= 0; i--) begin
            if (fwd_en[i] && (src != '0) &&
                (fwd_addr[i*REG_AW +: REG_AW] == src)) begin
                value   = fwd_data[i*DATA_W +: DATA_W];
                pending = fwd_pending[i];
            end
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Registered ID->EX operand generator with forwarding,
// load-use stall and a valid/ready output register.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int FWD_PORTS = 2,
    parameter int REG_AW    = 5,
    parameter int LINK_OFS  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [5:0]                  op,
    input  logic [5:0]                  funct,
    input  logic [15:0]                 imm,
    input  logic [REG_AW-1:0]           rs_addr,
    input  logic [REG_AW-1:0]           rt_addr,
    input  logic [DATA_W-1:0]           reg_data_1,
    input  logic [DATA_W-1:0]           reg_data_2,
    input  logic [FWD_PORTS-1:0]        fwd_en,
    input  logic [FWD_PORTS-1:0]        fwd_pending,
    input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr,
    input  logic [FWD_PORTS*DATA_W-1:0] fwd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           operand_1,
    output logic [DATA_W-1:0]           operand_2,
    output logic [DATA_W-1:0]           store_data
);

    dec_t              dec;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              rs_pend;
    logic              rt_pend;
    logic [ADDR_W-1:0] link_addr;
    logic [DATA_W-1:0] link_val;
    logic [DATA_W-1:0] simm_val;
    logic [DATA_W-1:0] zimm_val;
    logic [DATA_W-1:0] himm_val;
    logic [DATA_W-1:0] op1_nxt;
    logic [DATA_W-1:0] op2_nxt;
    logic [DATA_W-1:0] sd_nxt;
    logic              hazard;
    logic              load_en;
    logic              take;

    assign dec = decode(op, funct);

    operand_fwd_sel #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .FWD_PORTS (FWD_PORTS)
    ) u_fwd_rs (
        .src         (rs_addr),
        .reg_data    (reg_data_1),
        .fwd_en      (fwd_en),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (rs_val),
        .pending     (rs_pend)
    );

    operand_fwd_sel #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .FWD_PORTS (FWD_PORTS)
    ) u_fwd_rt (
        .src         (rt_addr),
        .reg_data    (reg_data_2),
        .fwd_en      (fwd_en),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .value       (rt_val),
        .pending     (rt_pend)
    );

    // Link wraps in the address domain before resizing to data width.
    assign link_addr = addr + ADDR_W'(LINK_OFS);
    assign link_val  = DATA_W'(link_addr);
    assign simm_val  = {{(DATA_W-16){imm[15]}}, imm};
    assign zimm_val  = {{(DATA_W-16){1'b0}}, imm};
    assign himm_val  = DATA_W'({imm, 16'h0000});

    // Operand 1 mux.
    always_comb begin
        op1_nxt = '0;
        unique case (dec.sel_1)
            OPSEL_REG:  op1_nxt = rs_val;
            OPSEL_LINK: op1_nxt = link_val;
            default:    op1_nxt = '0;
        endcase
    end

    // Operand 2 mux.
    always_comb begin
        op2_nxt = '0;
        unique case (dec.sel_2)
            OPSEL_REG:  op2_nxt = rt_val;
            OPSEL_SIMM: op2_nxt = simm_val;
            OPSEL_ZIMM: op2_nxt = zimm_val;
            OPSEL_HIMM: op2_nxt = himm_val;
            default:    op2_nxt = '0;
        endcase
    end

    assign sd_nxt = dec.store ? rt_val : '0;

    assign hazard = in_valid &&
                    ((dec.rs_used && rs_pend) ||
                     (dec.rt_used && rt_pend));

    assign load_en  = !out_valid || out_ready;
    assign take     = in_valid && !hazard;
    assign in_ready = rst && ((load_en && !hazard) || flush);

    // Output register: flush wins, bubbles keep old operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            operand_1  <= '0;
            operand_2  <= '0;
            store_data <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load_en) begin
            out_valid <= take;
            if (take) begin
                operand_1  <= op1_nxt;
                operand_2  <= op2_nxt;
                store_data <= sd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed cases
// plus randomized traffic against a behavioural model.
module tb_operand_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NP = 2;
    localparam int RW = 5;
    localparam int LO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    addr;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [15:0]      imm;
    logic [RW-1:0]    rs_addr;
    logic [RW-1:0]    rt_addr;
    logic [DW-1:0]    reg_data_1;
    logic [DW-1:0]    reg_data_2;
    logic [NP-1:0]    fwd_en;
    logic [NP-1:0]    fwd_pending;
    logic [NP*RW-1:0] fwd_addr;
    logic [NP*DW-1:0] fwd_data;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    operand_1;
    logic [DW-1:0]    operand_2;
    logic [DW-1:0]    store_data;

    int n_cmp = 0;
    int n_err = 0;

    logic        m_valid;
    logic [31:0] m_op1;
    logic [31:0] m_op2;
    logic [31:0] m_sd;
    logic [31:0] e_op1;
    logic [31:0] e_op2;
    logic [31:0] e_sd;
    logic        e_hz;

    operand_stage #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .FWD_PORTS (NP),
        .REG_AW    (RW),
        .LINK_OFS  (LO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .addr        (addr),
        .op          (op),
        .funct       (funct),
        .imm         (imm),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .reg_data_1  (reg_data_1),
        .reg_data_2  (reg_data_2),
        .fwd_en      (fwd_en),
        .fwd_pending (fwd_pending),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operand_1   (operand_1),
        .operand_2   (operand_2),
        .store_data  (store_data)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // First matching port in index order wins; r0 reads the register file.
    function automatic logic [31:0] resolve(input logic [4:0] s,
                                            input logic [31:0] rf,
                                            output logic pend);
        logic [31:0] v;
        logic        found;
        v     = rf;
        pend  = 1'b0;
        found = 1'b0;
        if (s != 5'd0) begin
            for (int i = 0; i < NP; i++) begin
                if (!found && fwd_en[i] && fwd_addr[i*RW +: RW] == s) begin
                    found = 1'b1;
                    v     = fwd_data[i*DW +: DW];
                    pend  = fwd_pending[i];
                end
            end
        end
        return v;
    endfunction

    function automatic void calc(output logic [31:0] o1,
                                 output logic [31:0] o2,
                                 output logic [31:0] sd,
                                 output logic hz);
        logic [31:0] v1;
        logic [31:0] v2;
        logic        p1;
        logic        p2;
        logic        is_st;
        logic        is_ld;
        logic        u1;
        logic        u2;
        v1    = resolve(rs_addr, reg_data_1, p1);
        v2    = resolve(rt_addr, reg_data_2, p2);
        is_st = op inside {6'h28, 6'h29, 6'h2B};
        is_ld = op inside {6'h20, 6'h21, 6'h23, 6'h24};
        u1    = (op == 6'h00 && funct != 6'h09) || is_st || is_ld ||
                op inside {6'h09, 6'h0F, 6'h0C, 6'h0D};
        u2    = (op == 6'h00) || is_st;
        if (op == 6'h03 || (op == 6'h00 && funct == 6'h09))
            o1 = addr + 32'd8;
        else if (u1)
            o1 = v1;
        else
            o1 = 32'h0;
        if (op == 6'h0F)
            o2 = {imm, 16'h0000};
        else if (op == 6'h09 || is_ld || is_st)
            o2 = {{16{imm[15]}}, imm};
        else if (op inside {6'h0C, 6'h0D})
            o2 = {16'h0000, imm};
        else if (op == 6'h00)
            o2 = v2;
        else
            o2 = 32'h0;
        sd = is_st ? v2 : 32'h0;
        hz = in_valid && ((u1 && p1) || (u2 && p2));
    endfunction

    always_comb begin
        e_op1 = 32'h0;
        e_op2 = 32'h0;
        e_sd  = 32'h0;
        e_hz  = 1'b0;
        calc(e_op1, e_op2, e_sd, e_hz);
    end

    // Reference output register.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_op1   <= 32'h0;
            m_op2   <= 32'h0;
            m_sd    <= 32'h0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!m_valid || out_ready) begin
            if (in_valid && !e_hz) begin
                m_valid <= 1'b1;
                m_op1   <= e_op1;
                m_op2   <= e_op2;
                m_sd    <= e_sd;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check("out_valid", out_valid, m_valid);
        check("operand_1", operand_1, m_op1);
        check("operand_2", operand_2, m_op2);
        check("store_data", store_data, m_sd);
        check("in_ready", in_ready,
              rst && ((((!m_valid) || out_ready) && !e_hz) || flush));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ins(input logic [5:0] o, input logic [5:0] f,
                           input logic [15:0] im, input logic [31:0] a,
                           input logic [4:0] s, input logic [4:0] t,
                           input logic [31:0] r1, input logic [31:0] r2);
        op         = o;
        funct      = f;
        imm        = im;
        addr       = a;
        rs_addr    = s;
        rt_addr    = t;
        reg_data_1 = r1;
        reg_data_2 = r2;
        in_valid   = 1'b1;
    endtask

    logic [5:0] ops [0:15] = '{
        6'h00, 6'h00, 6'h03, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h20,
        6'h21, 6'h23, 6'h24, 6'h28, 6'h29, 6'h2B, 6'h02, 6'h0A
    };

    initial begin
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        addr        = '0;
        op          = '0;
        funct       = '0;
        imm         = '0;
        rs_addr     = '0;
        rt_addr     = '0;
        reg_data_1  = '0;
        reg_data_2  = '0;
        fwd_en      = '0;
        fwd_pending = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_valid", out_valid, 0);
        check("rst_op1", operand_1, 0);
        check("rst_rdy", in_ready, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        set_ins(6'h09, 6'h00, 16'hFFFF, 32'h100, 5'd3, 5'd0,
                32'h10, 32'h0);
        #1 check("addiu_rdy", in_ready, 1);
        step();
        check("addiu_v", out_valid, 1);
        check("addiu_op1", operand_1, 32'h10);
        check("addiu_op2", operand_2, 32'hFFFF_FFFF);

        set_ins(6'h03, 6'h00, 16'h0, 32'hFFFF_FFFC, 5'd0, 5'd0, 0, 0);
        step();
        check("jal_op1", operand_1, 32'h4);
        check("jal_op2", operand_2, 32'h0);

        set_ins(6'h0F, 6'h00, 16'h1234, 32'h0, 5'd0, 5'd0, 0, 0);
        step();
        check("lui_op2", operand_2, 32'h1234_0000);

        set_ins(6'h0D, 6'h00, 16'h8000, 32'h0, 5'd0, 5'd0, 0, 0);
        step();
        check("ori_op2", operand_2, 32'h0000_8000);

        fwd_en   = 2'b11;
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'hBB, 32'hAA};
        set_ins(6'h00, 6'h21, 16'h0, 32'h0, 5'd5, 5'd6, 32'h11, 32'h22);
        step();
        check("fwd_prio_op1", operand_1, 32'hAA);
        check("fwd_prio_op2", operand_2, 32'h22);

        fwd_en   = 2'b01;
        fwd_addr = {5'd0, 5'd0};
        fwd_data = {32'h0, 32'hCC};
        set_ins(6'h00, 6'h21, 16'h0, 32'h0, 5'd0, 5'd0, 32'h77, 32'h99);
        step();
        check("r0_op1", operand_1, 32'h77);
        check("r0_op2", operand_2, 32'h99);

        fwd_en      = 2'b10;
        fwd_addr    = {5'd7, 5'd0};
        fwd_pending = 2'b10;
        fwd_data    = {32'h0, 32'h0};
        set_ins(6'h2B, 6'h00, 16'h4, 32'h0, 5'd2, 5'd7,
                32'h1000, 32'h11);
        repeat (2) begin
            #1 check("sw_stall_rdy", in_ready, 0);
            step();
            check("sw_bubble", out_valid, 0);
        end
        fwd_pending = 2'b00;
        fwd_data    = {32'h55, 32'h0};
        #1 check("sw_go_rdy", in_ready, 1);
        step();
        check("sw_v", out_valid, 1);
        check("sw_sd", store_data, 32'h55);
        check("sw_op1", operand_1, 32'h1000);
        check("sw_op2", operand_2, 32'h4);

        fwd_en    = '0;
        out_ready = 1'b0;
        set_ins(6'h09, 6'h00, 16'h1, 32'h0, 5'd1, 5'd0, 32'h5, 32'h0);
        repeat (3) begin
            #1 check("hold_rdy", in_ready, 0);
            step();
            check("hold_v", out_valid, 1);
            check("hold_op1", operand_1, 32'h1000);
            check("hold_op2", operand_2, 32'h4);
            check("hold_sd", store_data, 32'h55);
        end
        flush = 1'b1;
        #1 check("flush_rdy", in_ready, 1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_v", out_valid, 0);
        out_ready = 1'b1;

        repeat (3000) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            op          = ops[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            case ($urandom_range(0, 2))
                0:       funct = 6'h09;
                1:       funct = 6'h21;
                default: funct = 6'($urandom);
            endcase
            imm         = 16'($urandom);
            addr        = $urandom;
            rs_addr     = 5'($urandom_range(0, 7));
            rt_addr     = 5'($urandom_range(0, 7));
            reg_data_1  = $urandom;
            reg_data_2  = $urandom;
            fwd_en      = 2'($urandom);
            fwd_pending = {($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 3) == 0)};
            fwd_addr    = {5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7))};
            fwd_data    = {$urandom, $urandom};
            step();
        end

        flush     = 1'b0;
        fwd_en    = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        set_ins(6'h09, 6'h00, 16'h1, 32'h0, 5'd1, 5'd0, 32'h1234, 32'h0);
        step();
        in_valid = 1'b0;
        check("pre_rst_v", out_valid, 1);
        rst = 1'b0;
        #1;
        check("async_rst_v", out_valid, 0);
        check("async_rst_op1", operand_1, 0);
        check("async_rst_op2", operand_2, 0);
        check("async_rst_sd", store_data, 0);
        check("async_rst_rdy", in_ready, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
